// File: rtl/ml_pkg.sv
// Shared fixed-point constants, FSM state type and saturation helper for the ML datapath blocks.
package ml_pkg;

  localparam int unsigned DefWidth    = 32;
  localparam int unsigned DefFracBits = 16;
  // Widest intermediate the saturation helper accepts; callers sign-extend into this.
  localparam int unsigned SatW        = 128;

  typedef enum logic [1:0] {StIdle, StRun, StDone} fsm_state_e;

  // Clamp a signed value to the range of a w-bit two's-complement word.
  function automatic logic signed [SatW-1:0] sat_to_width(input logic signed [SatW-1:0] v,
                                                          input int unsigned w);
    logic signed [SatW-1:0] one;
    logic signed [SatW-1:0] hi;
    logic signed [SatW-1:0] lo;
    one = SatW'(1);
    hi  = (one <<< (w - 1)) - one;
    lo  = -(one <<< (w - 1));
    if (v > hi) begin
      return hi;
    end else if (v < lo) begin
      return lo;
    end
    return v;
  endfunction

endpackage

// File: rtl/mac_unit.sv
// Signed multiply-accumulate; clear_i loads the product instead of adding so neurons chain back to back.
module mac_unit #(
  parameter int unsigned Width = 32,
  parameter int unsigned AccW  = 66
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   en_i,
  input  logic                   clear_i,
  input  logic signed [Width-1:0] a_i,
  input  logic signed [Width-1:0] b_i,
  output logic signed [AccW-1:0]  acc_o
);

  localparam int unsigned ProdW = 2 * Width;

  logic signed [ProdW-1:0] prod;
  logic signed [AccW-1:0]  acc_d, acc_q;

  always_comb begin
    prod  = ProdW'(a_i) * ProdW'(b_i);
    acc_d = acc_q;
    if (en_i) begin
      acc_d = clear_i ? AccW'(prod) : acc_q + AccW'(prod);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/fc_layer_seq.sv
// Sequential fully-connected layer: streams weights from an external memory through one shared MAC
// and finalizes each neuron (shift, bias, saturate, optional ReLU) into a registered output vector.
module fc_layer_seq
  import ml_pkg::*;
#(
  parameter int unsigned WIDTH      = DefWidth,
  parameter int unsigned FRAC_BITS  = DefFracBits,
  parameter int unsigned IN_LENGTH  = 16,
  parameter int unsigned OUT_LENGTH = 16
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [IN_LENGTH*WIDTH-1:0]             inputs,
  input  logic [OUT_LENGTH*WIDTH-1:0]            biases,
  input  logic                                   relu_en,
  output logic                                   w_rd_en,
  output logic [$clog2(OUT_LENGTH*IN_LENGTH)-1:0] w_addr,
  input  logic [WIDTH-1:0]                       w_data,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [OUT_LENGTH*WIDTH-1:0]            outputs,
  output logic                                   busy
);

  localparam int unsigned NTotal = OUT_LENGTH * IN_LENGTH;
  localparam int unsigned AW     = $clog2(NTotal);
  localparam int unsigned IW     = (IN_LENGTH > 1) ? $clog2(IN_LENGTH) : 1;
  localparam int unsigned OW     = (OUT_LENGTH > 1) ? $clog2(OUT_LENGTH) : 1;
  localparam int unsigned AccW   = 2 * WIDTH + $clog2(IN_LENGTH);

  fsm_state_e state_d, state_q;
  logic [IN_LENGTH*WIDTH-1:0]  x_d, x_q;
  logic [OUT_LENGTH*WIDTH-1:0] b_d, b_q;
  logic [OUT_LENGTH*WIDTH-1:0] out_d, out_q;
  logic                        relu_d, relu_q;
  logic                        rd_en_d, rd_en_q;
  logic [AW-1:0]               addr_d, addr_q;
  logic [IW-1:0]               i_d, i_q;
  logic [OW-1:0]               o_d, o_q;
  // Data stage: w_data on the bus belongs to the read issued one cycle earlier.
  logic                        dv_d, dv_q;
  logic [IW-1:0]               di_d, di_q;
  logic [OW-1:0]               do_d, do_q;
  // Finalize stage: accumulator holds a complete neuron sum for neuron fo_q.
  logic                        fin_d, fin_q;
  logic [OW-1:0]               fo_d, fo_q;

  logic signed [AccW-1:0]  acc;
  logic signed [AccW-1:0]  acc_shift;
  logic signed [AccW:0]    biased;
  logic signed [WIDTH-1:0] bias_sel;
  logic signed [SatW-1:0]  sat_v;
  logic [WIDTH-1:0]        fin_val;

  mac_unit #(
    .Width (WIDTH),
    .AccW  (AccW)
  ) u_mac (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .en_i    (dv_q),
    .clear_i (di_q == '0),
    .a_i     ($signed(w_data)),
    .b_i     ($signed(x_q[di_q*WIDTH +: WIDTH])),
    .acc_o   (acc)
  );

  always_comb begin
    acc_shift = acc >>> FRAC_BITS;
    bias_sel  = $signed(b_q[fo_q*WIDTH +: WIDTH]);
    biased    = (AccW+1)'(acc_shift) + (AccW+1)'(bias_sel);
    sat_v     = sat_to_width(SatW'(biased), WIDTH);
    if (relu_q && (sat_v < 0)) begin
      sat_v = '0;
    end
    fin_val = sat_v[WIDTH-1:0];
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    b_d     = b_q;
    relu_d  = relu_q;
    rd_en_d = rd_en_q;
    addr_d  = addr_q;
    i_d     = i_q;
    o_d     = o_q;
    out_d   = out_q;
    dv_d    = rd_en_q;
    di_d    = i_q;
    do_d    = o_q;
    fin_d   = dv_q && (di_q == IW'(IN_LENGTH - 1));
    fo_d    = do_q;

    case (state_q)
      StIdle: begin
        if (in_valid) begin
          state_d = StRun;
          x_d     = inputs;
          b_d     = biases;
          relu_d  = relu_en;
          rd_en_d = 1'b1;
          addr_d  = '0;
          i_d     = '0;
          o_d     = '0;
        end
      end
      StRun: begin
        if (rd_en_q) begin
          if (addr_q == AW'(NTotal - 1)) begin
            rd_en_d = 1'b0;
          end else begin
            addr_d = addr_q + AW'(1);
          end
          if (i_q == IW'(IN_LENGTH - 1)) begin
            i_d = '0;
            o_d = o_q + OW'(1);
          end else begin
            i_d = i_q + IW'(1);
          end
        end
        if (fin_q && (fo_q == OW'(OUT_LENGTH - 1))) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (fin_q) begin
      out_d[fo_q*WIDTH +: WIDTH] = fin_val;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      x_q     <= '0;
      b_q     <= '0;
      relu_q  <= 1'b0;
      rd_en_q <= 1'b0;
      addr_q  <= '0;
      i_q     <= '0;
      o_q     <= '0;
      out_q   <= '0;
      dv_q    <= 1'b0;
      di_q    <= '0;
      do_q    <= '0;
      fin_q   <= 1'b0;
      fo_q    <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      b_q     <= b_d;
      relu_q  <= relu_d;
      rd_en_q <= rd_en_d;
      addr_q  <= addr_d;
      i_q     <= i_d;
      o_q     <= o_d;
      out_q   <= out_d;
      dv_q    <= dv_d;
      di_q    <= di_d;
      do_q    <= do_d;
      fin_q   <= fin_d;
      fo_q    <= fo_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign w_rd_en   = rd_en_q;
  assign w_addr    = addr_q;
  assign outputs   = out_q;

endmodule

// File: tb/tb_fc_layer_seq.sv
// Scoreboard bench for fc_layer_seq (IN_LENGTH=4, OUT_LENGTH=2, Q16.16): directed vectors, latency,
// backpressure, address sequence and mid-run reset.
module tb_fc_layer_seq;

  localparam int unsigned W   = 32;
  localparam int unsigned IN  = 4;
  localparam int unsigned OUT = 2;
  localparam logic [31:0] ONE = 32'h0001_0000;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [IN*W-1:0]  inputs = '0;
  logic [OUT*W-1:0] biases = '0;
  logic             relu_en = 1'b0;
  logic             w_rd_en;
  logic [2:0]       w_addr;
  logic [W-1:0]     w_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [OUT*W-1:0] outputs;
  logic             busy;

  logic [W-1:0] w_mem [8];

  int unsigned      n_tests = 0;
  int unsigned      n_fail = 0;
  int unsigned      cyc = 0;
  int unsigned      acc_cyc = 0;
  logic             ov_prev = 1'b0;
  logic [OUT*W-1:0] exp_q [$];
  string            tag_q [$];

  fc_layer_seq #(
    .WIDTH      (W),
    .FRAC_BITS  (16),
    .IN_LENGTH  (IN),
    .OUT_LENGTH (OUT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .inputs    (inputs),
    .biases    (biases),
    .relu_en   (relu_en),
    .w_rd_en   (w_rd_en),
    .w_addr    (w_addr),
    .w_data    (w_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .outputs   (outputs),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Weight memory with one cycle read latency.
  always @(posedge clk) begin
    if (w_rd_en) w_data <= w_mem[w_addr];
  end

  always @(posedge clk) begin
    cyc++;
    if (rst_n && in_valid && in_ready) acc_cyc = cyc;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: latency on out_valid rise, pop and compare on every output handshake.
  always @(negedge clk) begin
    if (!rst_n) begin
      ov_prev = 1'b0;
    end else begin
      if (out_valid && !ov_prev) chk("latency", 64'(cyc - acc_cyc), 64'd10);
      ov_prev = out_valid;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", 64'd1, 64'd0);
        end else begin
          chk(tag_q.pop_front(), outputs, exp_q.pop_front());
        end
      end
    end
  end

  task automatic load_w(input logic [W-1:0] w0, input logic [W-1:0] w1);
    for (int k = 0; k < 4; k++) begin
      w_mem[k]     = w0;
      w_mem[k + 4] = w1;
    end
  endtask

  task automatic accept(input logic [IN*W-1:0] x, input logic [OUT*W-1:0] b, input logic rl);
    @(posedge clk); #1;
    inputs   = x;
    biases   = b;
    relu_en  = rl;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    inputs   = ~x;
    biases   = ~b;
    relu_en  = ~rl;
  endtask

  task automatic run(input string tag, input logic [IN*W-1:0] x, input logic [W-1:0] w0,
                     input logic [W-1:0] w1, input logic [OUT*W-1:0] b, input logic rl,
                     input logic [OUT*W-1:0] exp, input bit chk_addr);
    int n;
    load_w(w0, w1);
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    accept(x, b, rl);
    if (chk_addr) begin
      for (int k = 0; k < 8; k++) begin
        chk("w_rd_en_on", 64'(w_rd_en), 64'd1);
        chk("w_addr_seq", 64'(w_addr), 64'(k));
        @(posedge clk); #1;
      end
      chk("w_rd_en_off", 64'(w_rd_en), 64'd0);
    end
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      chk({tag, "_timeout"}, 64'd1, 64'd0);
      exp_q.delete();
      tag_q.delete();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outputs", outputs, 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_w_rd_en", 64'(w_rd_en), 64'd0);
    chk("rst_w_addr", 64'(w_addr), 64'd0);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    run("basic", {4{ONE}}, ONE, ONE, {32'h0000_8000, 32'h0}, 1'b0,
        {32'h0004_8000, 32'h0004_0000}, 1'b1);
    run("relu_on", {4{ONE}}, 32'hFFFF_0000, 32'h0000_4000, 64'd0, 1'b1,
        {32'h0001_0000, 32'h0000_0000}, 1'b0);
    run("relu_off", {4{ONE}}, 32'hFFFF_0000, 32'h0000_4000, 64'd0, 1'b0,
        {32'h0001_0000, 32'hFFFC_0000}, 1'b0);
    run("sat_pos", {4{32'h7FFF_FFFF}}, 32'h7FFF_FFFF, 32'h7FFF_FFFF, {2{32'h7FFF_FFFF}}, 1'b0,
        {2{32'h7FFF_FFFF}}, 1'b0);
    run("sat_neg", {4{32'h7FFF_FFFF}}, 32'h8000_0001, 32'h8000_0001, {2{32'h7FFF_FFFF}}, 1'b0,
        {2{32'h8000_0000}}, 1'b0);
    run("floor_lsb", {96'd0, 32'hFFFF_FFFF}, 32'd1, 32'd1, {32'd5, 32'd0}, 1'b0,
        {32'h0000_0004, 32'hFFFF_FFFF}, 1'b0);

    // Backpressure: hold out_ready low for 20 cycles while poking in_valid.
    out_ready = 1'b0;
    load_w(ONE, ONE);
    exp_q.push_back({32'h0004_8000, 32'h0004_0000});
    tag_q.push_back("backpressure");
    accept({4{ONE}}, {32'h0000_8000, 32'h0}, 1'b0);
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("bp_out_valid_seen", 64'(out_valid), 64'd1);
    for (int k = 0; k < 20; k++) begin
      chk("bp_hold", outputs, {32'h0004_8000, 32'h0004_0000});
      chk("bp_in_ready_low", 64'(in_ready), 64'd0);
      in_valid = (k % 2 == 0);
      inputs   = {4{32'h1234_5678}};
      biases   = {2{32'h0BAD_0BAD}};
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_in_ready_after", 64'(in_ready), 64'd1);
    chk("bp_popped", 64'(exp_q.size()), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("bp_no_restart", 64'(busy), 64'd0);
    chk("bp_retain", outputs, {32'h0004_8000, 32'h0004_0000});

    // Reset five cycles into RUN aborts with nothing retained.
    load_w(ONE, 32'h0000_4000);
    accept({4{ONE}}, 64'd0, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_outputs", outputs, 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_w_rd_en", 64'(w_rd_en), 64'd0);
    chk("midrst_w_addr", 64'(w_addr), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    chk("midrst_outputs_rel", outputs, 64'd0);
    run("rerun", {4{ONE}}, ONE, ONE, {32'h0000_8000, 32'h0}, 1'b0,
        {32'h0004_8000, 32'h0004_0000}, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
